jt49_env_timer: RTL and testbench

Envelope timebase and register front-end that drives the envelope generator's step, null_period, restart and ctrl inputs. It captures CPU writes to envelope registers 11 (fine period), 12 (coarse period) and 13 (shape). It divides the core clock-enable down to a square-wave step signal whose rising edges pace the envelope. A shape write issues a one-clock restart pulse and realigns the timebase.

---
 rtl/jt49_env_timer.sv | 113 +++++++++++
 tb/tb_jt49_env_timer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_env_timer.sv
// Envelope timebase and register front-end for the jt49 envelope generator.
// Captures the envelope period/shape registers. It divides cen into ticks and
// produces a step square wave whose rising edges pace the envelope.

module jt49_env_timer #(
    parameter int DIV = 8,
    parameter int PW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          wr,
    input  logic [3:0]    addr,
    input  logic [7:0]    din,
    output logic          step,
    output logic          null_period,
    output logic          restart,
    output logic [3:0]    ctrl,
    output logic [PW-1:0] period
);

    localparam int             PSW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(DIV - 1);

    localparam logic [3:0] ADDR_FINE   = 4'd11;
    localparam logic [3:0] ADDR_COARSE = 4'd12;
    localparam logic [3:0] ADDR_SHAPE  = 4'd13;

    logic [7:0]     fine_q, fine_d;
    logic [7:0]     coarse_q, coarse_d;
    logic [3:0]     ctrl_q, ctrl_d;
    logic [PSW-1:0] pre_q, pre_d;
    logic [PW-1:0]  count_q, count_d;
    logic           step_q, step_d;
    logic           restart_q, restart_d;
    logic           tick;
    logic [PW-1:0]  period_q;

    // The period is made only of registered bytes, so nothing from wr/din reaches the outputs combinationally
    assign period_q = {coarse_q, fine_q};

    // Next-state logic: prescaler, half-period counter, then register writes.
    // A shape write comes last so that it overrides a simultaneous tick.
    always_comb begin
        fine_d    = fine_q;
        coarse_d  = coarse_q;
        ctrl_d    = ctrl_q;
        pre_d     = pre_q;
        count_d   = count_q;
        step_d    = step_q;
        restart_d = 1'b0;
        tick      = cen && (pre_q == PS_LAST);

        if (cen) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end

        if (tick) begin
            if (period_q == '0) begin
                count_d = '0;
                step_d  = 1'b0;
            end else if (count_q >= period_q - PW'(1)) begin
                count_d = '0;
                step_d  = ~step_q;
            end else begin
                count_d = count_q + PW'(1);
            end
        end

        if (wr) begin
            case (addr)
                ADDR_FINE:   fine_d   = din;
                ADDR_COARSE: coarse_d = din;
                ADDR_SHAPE: begin
                    ctrl_d    = din[3:0];
                    pre_d     = '0;
                    count_d   = '0;
                    step_d    = 1'b0;
                    restart_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset taking priority over writes and cen
    always_ff @(posedge clk) begin
        if (rst) begin
            fine_q    <= '0;
            coarse_q  <= '0;
            ctrl_q    <= '0;
            pre_q     <= '0;
            count_q   <= '0;
            step_q    <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            fine_q    <= fine_d;
            coarse_q  <= coarse_d;
            ctrl_q    <= ctrl_d;
            pre_q     <= pre_d;
            count_q   <= count_d;
            step_q    <= step_d;
            restart_q <= restart_d;
        end
    end

    assign step        = step_q;
    assign restart     = restart_q;
    assign ctrl        = ctrl_q;
    assign period      = period_q;
    assign null_period = (period_q == '0);

endmodule

// File: tb/tb_jt49_env_timer.sv
// Self-checking bench for jt49_env_timer. Two instances run side by side:
// one with DIV=8 and one with DIV=2. They share the register bus and each has its own cen.
// Both are compared every cycle against a tick-level behavioural model.

module tb_jt49_env_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen8 = 1'b0;
    logic        cen2 = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [7:0]  din = 8'd0;

    logic        step8, null8, restart8;
    logic [3:0]  ctrl8;
    logic [15:0] period8;
    logic        step2, null2, restart2;
    logic [3:0]  ctrl2;
    logic [15:0] period2;

    int checks = 0;
    int errors = 0;

    jt49_env_timer #(.DIV(8), .PW(16)) u8 (
        .clk(clk), .rst(rst), .cen(cen8), .wr(wr), .addr(addr), .din(din),
        .step(step8), .null_period(null8), .restart(restart8), .ctrl(ctrl8), .period(period8)
    );

    jt49_env_timer #(.DIV(2), .PW(16)) u2 (
        .clk(clk), .rst(rst), .cen(cen2), .wr(wr), .addr(addr), .din(din),
        .step(step2), .null_period(null2), .restart(restart2), .ctrl(ctrl2), .period(period2)
    );

    always #5 clk = ~clk;

    // Model state: cens seen in the current tick window, completed ticks in the current
    // half period, step level, restart pulse and register contents
    typedef struct {
        int div;
        int cens;
        int ticks;
        int stp;
        int rs;
        int fine;
        int coarse;
        int ctrl;
    } mdl_t;

    mdl_t m8, m2;

    // One clock of behaviour from the rules: every DIV cens make a tick.
    // Every P ticks flip step; a period of 0 parks step low.
    // A shape write restarts everything.
    function automatic mdl_t mdl_next(mdl_t m, bit r, bit c, bit w, int a, int d);
        mdl_t n = m;
        int   per;
        bit   tk;
        n.rs = 0;
        if (r) begin
            n.cens = 0; n.ticks = 0; n.stp = 0; n.fine = 0; n.coarse = 0; n.ctrl = 0;
            return n;
        end
        per = m.coarse * 256 + m.fine;
        tk  = c && (m.cens + 1 == m.div);
        if (c) n.cens = tk ? 0 : m.cens + 1;
        if (tk) begin
            if (per == 0) begin
                n.ticks = 0; n.stp = 0;
            end else if (m.ticks + 1 >= per) begin
                n.ticks = 0; n.stp = 1 - m.stp;
            end else begin
                n.ticks = m.ticks + 1;
            end
        end
        if (w) begin
            if (a == 11) n.fine = d;
            else if (a == 12) n.coarse = d;
            else if (a == 13) begin
                n.ctrl = d % 16; n.cens = 0; n.ticks = 0; n.stp = 0; n.rs = 1;
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic checkModel();
        checkOutput("u8.step",    int'(step8),    m8.stp);
        checkOutput("u8.restart", int'(restart8), m8.rs);
        checkOutput("u8.ctrl",    int'(ctrl8),    m8.ctrl);
        checkOutput("u8.period",  int'(period8),  m8.coarse * 256 + m8.fine);
        checkOutput("u8.null",    int'(null8),    (m8.coarse * 256 + m8.fine == 0) ? 1 : 0);
        checkOutput("u2.step",    int'(step2),    m2.stp);
        checkOutput("u2.restart", int'(restart2), m2.rs);
        checkOutput("u2.ctrl",    int'(ctrl2),    m2.ctrl);
        checkOutput("u2.period",  int'(period2),  m2.coarse * 256 + m2.fine);
        checkOutput("u2.null",    int'(null2),    (m2.coarse * 256 + m2.fine == 0) ? 1 : 0);
    endtask

    // Drive one clock of inputs at the falling edge, advance the model and compare after the rising edge
    task automatic applyStimulus(input bit r, input bit c8, input bit c2,
                                 input bit w, input logic [3:0] a, input logic [7:0] d);
        mdl_t n8, n2;
        @(negedge clk);
        rst = r; cen8 = c8; cen2 = c2; wr = w; addr = a; din = d;
        n8 = mdl_next(m8, r, c8, w, int'(a), int'(d));
        n2 = mdl_next(m2, r, c2, w, int'(a), int'(d));
        @(posedge clk);
        #1;
        m8 = n8;
        m2 = n2;
        checkModel();
    endtask

    task automatic idle(input bit c8, input bit c2);
        applyStimulus(1'b0, c8, c2, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic write(input bit c8, input logic [3:0] a, input logic [7:0] d);
        applyStimulus(1'b0, c8, 1'b0, 1'b1, a, d);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    typedef struct {
        logic        r, c, w;
        logic [3:0]  a;
        logic [7:0]  d;
        logic        e_step, e_rs, e_null;
        logic [3:0]  e_ctrl;
        logic [15:0] e_period;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int t_first, t_second, t_third, k;
        logic prev;

        m8 = '{div: 8, default: 0};
        m2 = '{div: 2, default: 0};

        // Register front-end vectors, cen held low so the timebase stays parked
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 4'd13, 8'h0F, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'd13, 8'h0F, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0000};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 4'd13, 8'h0F, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0000};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'd11, 8'h03, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0003};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd12, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0003};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'd7,  8'hFF, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0003};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'd13, 8'hFE, 1'b0, 1'b1, 1'b0, 4'hE, 16'h0003};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b0, 4'hE, 16'h0003};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd13, 8'h05, 1'b0, 1'b1, 1'b0, 4'h5, 16'h0003};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'd13, 8'h03, 1'b0, 1'b1, 1'b0, 4'h3, 16'h0003};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 4'd12, 8'h2A, 1'b0, 1'b0, 1'b0, 4'h3, 16'h2A03};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b0, 4'h3, 16'h2A03};

        $display("[TB] register vectors");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].r, vecs[i].c, vecs[i].c, vecs[i].w, vecs[i].a, vecs[i].d);
            checkOutput("vec.step",    int'(step8),    int'(vecs[i].e_step));
            checkOutput("vec.restart", int'(restart8), int'(vecs[i].e_rs));
            checkOutput("vec.null",    int'(null8),    int'(vecs[i].e_null));
            checkOutput("vec.ctrl",    int'(ctrl8),    int'(vecs[i].e_ctrl));
            checkOutput("vec.period",  int'(period8),  int'(vecs[i].e_period));
        end

        $display("[TB] basic timing DIV=8 period=3");
        doReset();
        write(1'b1, 4'd11, 8'd3);
        write(1'b1, 4'd12, 8'd0);
        write(1'b1, 4'd13, 8'h0E);
        checkOutput("basic.restart_hi", int'(restart8), 1);
        checkOutput("basic.ctrl", int'(ctrl8), 14);
        t_first = -1; t_second = -1;
        prev = step8;
        for (k = 1; k <= 100; k++) begin
            idle(1'b1, 1'b0);
            if (k == 1) checkOutput("basic.restart_lo", int'(restart8), 0);
            if (step8 && !prev) begin
                if (t_first < 0) t_first = k;
                else if (t_second < 0) t_second = k;
            end
            prev = step8;
        end
        checkOutput("basic.first_rise", t_first, 24);
        checkOutput("basic.rise_period", t_second - t_first, 48);

        $display("[TB] gated cen DIV=2 period=1");
        doReset();
        write(1'b0, 4'd11, 8'd1);
        write(1'b0, 4'd13, 8'h00);
        t_first = -1; t_second = -1; t_third = -1;
        prev = step2;
        for (k = 1; k <= 40; k++) begin
            idle(1'b0, (k % 4) == 0);
            if (step2 != prev) begin
                if (t_first < 0) t_first = k;
                else if (t_second < 0) t_second = k;
                else if (t_third < 0) t_third = k;
            end
            prev = step2;
        end
        checkOutput("gated.first_toggle", t_first, 8);
        checkOutput("gated.spacing1", t_second - t_first, 8);
        checkOutput("gated.spacing2", t_third - t_second, 8);

        $display("[TB] period shrink");
        doReset();
        write(1'b0, 4'd12, 8'h01);
        write(1'b0, 4'd13, 8'h00);
        for (k = 1; k <= 1600; k++) idle(1'b1, 1'b0);
        checkOutput("shrink.no_toggle_yet", int'(step8), 0);
        write(1'b1, 4'd11, 8'h10);
        write(1'b1, 4'd12, 8'h00);
        t_first = -1; t_second = -1;
        prev = step8;
        for (k = 1; k <= 200; k++) begin
            idle(1'b1, 1'b0);
            if (step8 != prev) begin
                if (t_first < 0) t_first = k;
                else if (t_second < 0) t_second = k;
            end
            prev = step8;
        end
        checkOutput("shrink.next_tick", t_first, 6);
        checkOutput("shrink.spacing", t_second - t_first, 128);

        $display("[TB] null period");
        doReset();
        write(1'b0, 4'd11, 8'd5);
        write(1'b0, 4'd13, 8'h00);
        for (k = 1; k <= 90; k++) idle(1'b1, 1'b0);
        write(1'b1, 4'd11, 8'd0);
        checkOutput("null.flag", int'(null8), 1);
        for (k = 1; k <= 20; k++) idle(1'b1, 1'b0);
        checkOutput("null.step_low", int'(step8), 0);
        write(1'b1, 4'd11, 8'd2);
        checkOutput("null.flag_clear", int'(null8), 0);
        t_first = -1; t_second = -1;
        prev = step8;
        for (k = 1; k <= 60; k++) begin
            idle(1'b1, 1'b0);
            if (step8 != prev) begin
                if (t_first < 0) t_first = k;
                else if (t_second < 0) t_second = k;
            end
            prev = step8;
        end
        checkOutput("null.resume_spacing", t_second - t_first, 16);

        $display("[TB] restart collision and burst");
        doReset();
        write(1'b0, 4'd11, 8'd2);
        write(1'b0, 4'd13, 8'h00);
        k = 0;
        while (!(m8.cens == 7 && m8.ticks + 1 >= 2) && k < 100) begin
            idle(1'b1, 1'b0);
            k++;
        end
        checkOutput("collide.found", (k < 100) ? 1 : 0, 1);
        checkOutput("collide.step_before", int'(step8), 0);
        write(1'b1, 4'd13, 8'h09);
        checkOutput("collide.step", int'(step8), 0);
        write(1'b1, 4'd13, 8'h0A);
        checkOutput("burst.restart1", int'(restart8), 1);
        write(1'b1, 4'd13, 8'h0C);
        checkOutput("burst.restart2", int'(restart8), 1);
        idle(1'b1, 1'b0);
        checkOutput("burst.restart_end", int'(restart8), 0);
        checkOutput("burst.ctrl", int'(ctrl8), 12);

        $display("[TB] randomized traffic");
        doReset();
        for (int i = 0; i < 3000; i++) begin
            bit          r, c8, c2, w;
            logic [3:0]  a;
            logic [7:0]  d;
            int          sel;
            r   = ($urandom_range(0, 499) == 0);
            c8  = ($urandom_range(0, 1) == 1);
            c2  = ($urandom_range(0, 3) != 0);
            w   = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 9);
            if (sel <= 2) begin
                a = 4'd11;
                d = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            end else if (sel <= 5) begin
                a = 4'd12;
                d = ($urandom_range(0, 9) == 0) ? 8'd1 : 8'd0;
            end else if (sel == 6) begin
                a = 4'd13;
                d = 8'($urandom);
            end else begin
                a = 4'($urandom);
                d = 8'($urandom);
            end
            applyStimulus(r, c8, c2, w, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
